// File: rtl/sudoku_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_pkg
// Shared definitions for the Sudoku board core:
//   state_t      - game state {LOAD, PLAY, CHECK, WON}
//   group_kind_t - validation group kind {ROW, COL, BOX}
//   EMPTY_CELL   - cell value meaning "no digit"
//   cell_idx()   - linear cell index, idx = row*n + col
// No ports (package).
// -----------------------------------------------------------------------------
package sudoku_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      PLAY  = 2'd1,
      CHECK = 2'd2,
      WON   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ROW = 2'd0,
      COL = 2'd1,
      BOX = 2'd2
   } group_kind_t;

   localparam int EMPTY_CELL = 0;

   function automatic int cell_idx(input int row, input int col, input int n);
      return row * n + col;
   endfunction

endpackage

// File: rtl/sudoku_group_checker.sv
// -----------------------------------------------------------------------------
// sudoku_group_checker
// Seen-digit accumulator for one validation group (row, column or box).
// One cell is presented per cycle; the element is bad if it is empty, not a
// legal digit, or its digit was already seen earlier in the same group.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   start         first element of a group: previous mask is disregarded
//   valid         a cell is presented this cycle (accumulate only when set)
//   cell_val      value of the presented cell
//   dup_or_empty  presented cell breaks the group (combinational)
//   mask          seen mask including the presented cell (combinational)
// -----------------------------------------------------------------------------
module sudoku_group_checker
   import sudoku_pkg::*;
#(
   parameter int GRID_N = 4,
   parameter int CELL_W = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic              valid,
   input  logic [CELL_W-1:0] cell_val,
   output logic              dup_or_empty,
   output logic [GRID_N-1:0] mask
);

   logic [GRID_N-1:0] seen_q;
   logic [GRID_N-1:0] base;
   logic [GRID_N-1:0] digit;

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      base  = start ? '0 : seen_q;
      digit = '0;
      for (int i = 0; i < GRID_N; i++) begin
         if (int'(cell_val) == i + 1) digit[i] = 1'b1;
      end
      // digit == 0 also covers out-of-range values that a load may have placed
      dup_or_empty = valid && ((int'(cell_val) == EMPTY_CELL) ||
                               (digit == '0) || ((base & digit) != '0));
      mask = base | digit;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RST) seen_q <= '0;
      else if (valid) seen_q <= mask;
   end

endmodule

// File: rtl/sudoku_board_core.sv
// -----------------------------------------------------------------------------
// sudoku_board_core
// N x N Sudoku game core: grid storage with per-cell given flags, button
// cursor, user writes, and a one-cell-per-cycle validation scan that raises
// win_ind when every group holds each digit exactly once.
// Build option: define SUDOKU_BOX_CHECK_EN to include the box groups in the
// scan (3*GRID_N groups); otherwise only rows and columns are scanned.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   load_we/idx/val/given         puzzle load port (LOAD state only)
//   load_done                     pulse, LOAD -> PLAY
//   user_num, write_sw            value and write request (rising edge acts)
//   up/down/left/right_btn        cursor buttons (rising edge acts)
//   rd_row, row_nums              registered display readout of one row
//   cur_num, cur_row, cur_col     cursor cell value and position
//   wp_ind, win_ind, busy         given flag at cursor, solved, scan running
//   wr_reject                     one-cycle pulse for a refused write
// -----------------------------------------------------------------------------
module sudoku_board_core
   import sudoku_pkg::*;
#(
   parameter int GRID_N = 4,
   parameter int BOX_N  = 2,
   parameter int CELL_W = 4,
   parameter int IDX_W  = $clog2(GRID_N*GRID_N),
   parameter int RC_W   = $clog2(GRID_N)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     load_we,
   input  logic [IDX_W-1:0]         load_idx,
   input  logic [CELL_W-1:0]        load_val,
   input  logic                     load_given,
   input  logic                     load_done,
   input  logic [CELL_W-1:0]        user_num,
   input  logic                     up_btn,
   input  logic                     down_btn,
   input  logic                     left_btn,
   input  logic                     right_btn,
   input  logic                     write_sw,
   input  logic [RC_W-1:0]          rd_row,
   output logic [GRID_N*CELL_W-1:0] row_nums,
   output logic [CELL_W-1:0]        cur_num,
   output logic [RC_W-1:0]          cur_row,
   output logic [RC_W-1:0]          cur_col,
   output logic                     wp_ind,
   output logic                     win_ind,
   output logic                     busy,
   output logic                     wr_reject
);

   localparam int CELLS = GRID_N * GRID_N;
`ifdef SUDOKU_BOX_CHECK_EN
   localparam int G = 3 * GRID_N;
`else
   localparam int G = 2 * GRID_N;
`endif
   localparam int GRP_W = $clog2(G);
   localparam logic [RC_W-1:0] LAST_RC = RC_W'(GRID_N - 1);

   if (GRID_N != BOX_N * BOX_N) begin : g_bad_geometry
      $error("sudoku_board_core: GRID_N must equal BOX_N*BOX_N");
   end

   state_t                    state;
   logic [CELL_W-1:0]         grid [CELLS];
   logic [CELLS-1:0]          given;
   logic [RC_W-1:0]           row_q, col_q;
   logic [3:0]                btn_prev;
   logic                      wr_prev;
   logic                      wr_reject_q;
   logic [GRID_N*CELL_W-1:0]  row_nums_q;
   logic [GRP_W-1:0]          grp;
   logic [RC_W-1:0]           elem;

   logic [3:0]                btn_rise;
   logic                      wr_rise;
   logic [IDX_W-1:0]          cur_idx;
   group_kind_t               kind;
   logic [RC_W-1:0]           scan_row, scan_col;
   logic [CELL_W-1:0]         scan_val;
   logic                      dup_or_empty;
   logic [GRID_N-1:0]         group_mask;

   // {up, down, left, right}: bit order doubles as move priority
   assign btn_rise = {up_btn, down_btn, left_btn, right_btn} & ~btn_prev;
   assign wr_rise  = write_sw & ~wr_prev;
   assign cur_idx  = IDX_W'(cell_idx(int'(row_q), int'(col_q), GRID_N));

   // Map scan position (group, element) to a grid cell
   always_comb begin
      kind     = ROW;
      scan_row = '0;
      scan_col = '0;
`ifdef SUDOKU_BOX_CHECK_EN
      if (int'(grp) >= 2 * GRID_N) kind = BOX;
      else
`endif
      if (int'(grp) >= GRID_N) kind = COL;
      case (kind)
         ROW: begin
            scan_row = RC_W'(grp);
            scan_col = elem;
         end
         COL: begin
            scan_row = elem;
            scan_col = RC_W'(int'(grp) - GRID_N);
         end
`ifdef SUDOKU_BOX_CHECK_EN
         BOX: begin
            scan_row = RC_W'(((int'(grp) - 2*GRID_N) / BOX_N) * BOX_N + int'(elem) / BOX_N);
            scan_col = RC_W'(((int'(grp) - 2*GRID_N) % BOX_N) * BOX_N + int'(elem) % BOX_N);
         end
`endif
         default: ;
      endcase
   end

   assign scan_val = grid[IDX_W'(cell_idx(int'(scan_row), int'(scan_col), GRID_N))];

   sudoku_group_checker #(
      .GRID_N (GRID_N),
      .CELL_W (CELL_W)
   ) u_checker (
      .CLK          (CLK),
      .RST          (RST),
      .start        (elem == '0),
      .valid        (state == CHECK),
      .cell_val     (scan_val),
      .dup_or_empty (dup_or_empty),
      .mask         (group_mask)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= LOAD;
         // NOTE: the grid is an explicit reset target (the board must read as
         // empty after reset), so it is cleared element by element here.
         for (int i = 0; i < CELLS; i++) grid[i] <= '0;
         given       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         btn_prev    <= '0;
         wr_prev     <= 1'b0;
         wr_reject_q <= 1'b0;
         row_nums_q  <= '0;
         grp         <= '0;
         elem        <= '0;
      end else begin
         btn_prev    <= {up_btn, down_btn, left_btn, right_btn};
         wr_prev     <= write_sw;
         wr_reject_q <= 1'b0;

         for (int c = 0; c < GRID_N; c++) begin
            row_nums_q[c*CELL_W +: CELL_W] <= grid[IDX_W'(cell_idx(int'(rd_row), c, GRID_N))];
         end

         if (state == PLAY || state == CHECK) begin
            if (btn_rise[3])      row_q <= (row_q == '0) ? LAST_RC : row_q - 1'b1;
            else if (btn_rise[2]) row_q <= (row_q == LAST_RC) ? '0 : row_q + 1'b1;
            else if (btn_rise[1]) col_q <= (col_q == '0) ? LAST_RC : col_q - 1'b1;
            else if (btn_rise[0]) col_q <= (col_q == LAST_RC) ? '0 : col_q + 1'b1;
         end

         case (state)
            LOAD: begin
               if (load_we && int'(load_idx) < CELLS) begin
                  grid[load_idx]  <= load_val;
                  given[load_idx] <= load_given;
               end
               if (load_done) state <= PLAY;
            end
            PLAY: begin
               if (wr_rise) begin
                  if (given[cur_idx] || int'(user_num) > GRID_N) begin
                     wr_reject_q <= 1'b1;
                  end else begin
                     grid[cur_idx] <= user_num;
                     state         <= CHECK;
                     grp           <= '0;
                     elem          <= '0;
                  end
               end
            end
            CHECK: begin
               if (wr_rise) wr_reject_q <= 1'b1;
               if (dup_or_empty) begin
                  state <= PLAY;
               end else if (elem == LAST_RC) begin
                  // a group only closes once every digit has been seen
                  if (!(&group_mask))       state <= PLAY;
                  else if (int'(grp) == G - 1) state <= WON;
                  else begin
                     grp  <= grp + 1'b1;
                     elem <= '0;
                  end
               end else begin
                  elem <= elem + 1'b1;
               end
            end
            WON: ;
            default: state <= LOAD;
         endcase
      end
   end

   assign row_nums  = row_nums_q;
   assign cur_num   = grid[cur_idx];
   assign cur_row   = row_q;
   assign cur_col   = col_q;
   assign wp_ind    = given[cur_idx];
   assign win_ind   = (state == WON);
   assign busy      = (state == CHECK);
   assign wr_reject = wr_reject_q;

endmodule

// File: doc/sudoku_board_core.md
Name: sudoku_board_core

Overview:
Parametrised game core for the next-generation Sudoku Master. It holds an N×N grid with per-cell given (write-protect) flags and a cursor driven by the four buttons. It commits user writes and runs a sequential row/column/box validation scan that raises the win indicator. The top level instantiates it beneath the 7-segment and row display drivers; it replaces the fixed 4×4 board logic.

Parameters:
GRID_N, 4, grid side; must equal BOX_N*BOX_N (elaboration error otherwise)
BOX_N, 2, box side
CELL_W, 4, bits per cell value; 0 = empty, legal digits 1..GRID_N
IDX_W, $clog2(GRID_N*GRID_N), linear cell index width (idx = row*GRID_N + col)
RC_W, $clog2(GRID_N), row/column index width

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
load_we  in  1  puzzle load strobe (LOAD state only)
load_idx  in  IDX_W  cell index for load
load_val  in  CELL_W  value loaded
load_given  in  1  mark loaded cell write-protected
load_done  in  1  pulse: LOAD -> PLAY
user_num  in  CELL_W  value to write at cursor
up_btn, down_btn, left_btn, right_btn  in  1 each  debounced level buttons
write_sw  in  1  write request, level; acts on rising edge
rd_row  in  RC_W  row selected for display readout
row_nums  out  GRID_N*CELL_W  cells of rd_row, col 0 in LSBs, registered
cur_num  out  CELL_W  value at cursor
cur_row, cur_col  out  RC_W each  cursor position
wp_ind  out  1  cursor cell is given
win_ind  out  1  board solved
busy  out  1  validation scan in progress
wr_reject  out  1  one-cycle pulse: write refused

Behaviour:
- Clock CLK; reset RST is synchronous and active-high. Everything is single-clock.
- Reset: grid and given flags cleared, cursor (0,0), state LOAD. All outputs 0; row_nums is 0 one cycle after reset.
- LOAD state:
  - load_we writes load_val and load_given at load_idx.
  - load_idx >= GRID_N² is ignored.
  - Buttons and write_sw are ignored.
  - load_done moves to PLAY next cycle. If load_done and load_we occur in the same cycle, the load is performed first.
- Buttons: each has a registered previous value; only rising edges act.
  - Priority when several rise in one cycle: up > down > left > right; only one move occurs.
  - Moves wrap: up from row 0 goes to GRID_N-1; right from GRID_N-1 goes to 0.
  - Cursor outputs update the cycle after the edge.
- Write, PLAY only: acts on a rising edge of write_sw.
  - Rejected, with a wr_reject pulse and no grid change, if the cell is given or user_num > GRID_N.
  - user_num = 0 clears the cell.
  - An accepted write updates the grid next cycle and enters CHECK.
- CHECK state:
  - busy = 1. Visits groups g = 0..G-1 (rows, then columns, then boxes), GRID_N elements each, one cell per cycle.
  - Keeps a GRID_N-bit seen mask, cleared at each group start.
  - Fails if a cell is 0 or its digit bit is already set. On failure, returns to PLAY the cycle after the failing element, with win_ind = 0.
  - Clean pass: exactly G*GRID_N cycles, then WON.
  - Box b, element e maps to row = (b/BOX_N)*BOX_N + e/BOX_N, col = (b%BOX_N)*BOX_N + e%BOX_N.
  - Cursor moves are honoured during CHECK.
  - A write edge during CHECK is not accepted: it pulses wr_reject.
- WON state: win_ind = 1 and busy = 0. Only RST leaves WON; buttons and writes are ignored, with no wr_reject.
- row_nums = grid row rd_row with one-cycle latency, valid in all states.
- cur_num and wp_ind are combinational from cursor and grid.
- Reset mid-CHECK: aborts the scan; the state is exactly the reset state.

Optional Feature:
SUDOKU_BOX_CHECK_EN.
- Defined: G = 3*GRID_N; box groups are scanned.
- Undefined: G = 2*GRID_N; rows and columns only, so the scan ends after 2*GRID_N² cycles. Box address logic is not built.

Decomposition:
- Package sudoku_pkg holds:
  - the state enum {LOAD, PLAY, CHECK, WON};
  - the group-kind enum {ROW, COL, BOX};
  - EMPTY_CELL = 0;
  - the function cell_idx(row, col, n).
- Sub-module sudoku_group_checker: the seen-mask accumulator, with inputs start, cell value and valid, and outputs dup_or_empty and mask.

Test Plan (GRID_N=4, BOX_N=2):
- Reset, then load a given 3 at idx 5 and load_done; write_sw rise with the cursor at (1,1) -> wr_reject pulse, cell stays 3, wp_ind = 1.
- Cursor at (0,0): up edge -> (3,0); left edge -> (3,3); up and right rising together -> only up applied, giving (2,3).
- Load the solved grid 1234/3412/2143/4321 minus cell (3,3), then write 1 at (3,3) -> busy for 48 cycles (32 without the macro), then win_ind = 1.
- Same grid, but write 2 at (3,3) -> the scan fails in row 3 and returns to PLAY, win_ind = 0, busy deasserted before cycle 48.
- user_num = 7 write -> wr_reject, no CHECK entry; user_num = 0 on a non-given cell -> cell cleared and CHECK fails at the first group.
- Assert RST mid-CHECK at cycle 10 -> next cycle all outputs are 0, state is LOAD, grid is zero.
